// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// write-port indices and the write-port record used for arbitration and bypass.
package regfile_pkg;

  localparam int PORT_WB = 0;
  localparam int PORT_LD = 1;
  localparam int NUM_WR  = 2;

  // Widest address/data a write-port record can carry; instances use the low bits.
  localparam int MAX_AW = 16;
  localparam int MAX_DW = 64;

  typedef struct packed {
    logic              we;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
  } wrPort_t;

  function automatic int calcAw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Pending-destination scoreboard: one bit per register, set by issue, cleared
// by writeback, with set taking priority; per-port registered lookup.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = calcAw(DEPTH)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               setEn,
  input  logic [AW-1:0]      setAddr,
  input  logic               clr0En,
  input  logic [AW-1:0]      clr0Addr,
  input  logic               clr1En,
  input  logic [AW-1:0]      clr1Addr,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD-1:0]  rbusy
);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pendNext;

  always_comb begin
    pendNext = pend;
    if (clr0En) pendNext[clr0Addr] = 1'b0;
    if (clr1En) pendNext[clr1Addr] = 1'b0;
    if (setEn)  pendNext[setAddr]  = 1'b1;
    if (ZERO_REG != 0) pendNext[0] = 1'b0;
  end

  // Lookup uses the post-edge bit so busy lines up with the bypassed read data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend  <= '0;
      rbusy <= '0;
    end else begin
      pend <= pendNext;
      for (int i = 0; i < NUM_RD; i++)
        rbusy[i] <= pendNext[raddr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (WB, LD wins on collision), NUM_RD
// registered write-first read ports, plus the pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = calcAw(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     we0,
  input  logic [AW-1:0]            waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [AW-1:0]            waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic [NUM_RD-1:0]        rbusy
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rdNext [NUM_RD];
  wrPort_t           wp [NUM_WR];
  logic              unusedData;

  always_comb begin
    wp[PORT_WB] = '{we: we0, addr: MAX_AW'(waddr0), data: MAX_DW'(wdata0)};
    wp[PORT_LD] = '{we: we1, addr: MAX_AW'(waddr1), data: MAX_DW'(wdata1)};
  end

  assign unusedData = ^{wp[PORT_WB].data, wp[PORT_LD].data};

  // Ports are visited in index order, so the LD port lands last and wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wp[p].we && !(ZERO_REG != 0 && wp[p].addr == '0))
          regs[wp[p].addr[AW-1:0]] <= wp[p].data[DATA_W-1:0];
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = raddr[i*AW +: AW];
      rdNext[i] = regs[a];
      for (int p = 0; p < NUM_WR; p++)
        if (wp[p].we && wp[p].addr == MAX_AW'(a))
          rdNext[i] = wp[p].data[DATA_W-1:0];
      if (ZERO_REG != 0 && a == '0) rdNext[i] = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        rdata[i*DATA_W +: DATA_W] <= rdNext[i];
    end
  end

  regfile_sb #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) uSb (
    .clock    (clock),
    .resetn   (resetn),
    .setEn    (sb_set),
    .setAddr  (sb_addr),
    .clr0En   (we0),
    .clr0Addr (waddr0),
    .clr1En   (we1),
    .clr1Addr (waddr1),
    .raddr    (raddr),
    .rbusy    (rbusy)
  );

endmodule
